// File: rtl/sseg_scan.sv
// sseg_scan: time-multiplexed driver for a bank of common-anode seven-segment
// digits. Frame-synchronous shadow buffering, PWM brightness per slot and
// leading blank cycles per slot to suppress ghosting. Panel outputs active-low.
module sseg_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int PWM_BITS = 4,
  parameter int BLANK    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DIGITS*4-1:0]   digit_val,
  input  logic [DIGITS-1:0]     digit_dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     com_out,
  output logic                  frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LW = $clog2(SCAN_DIV) + PWM_BITS + 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [LW-1:0] DIV_L   = LW'(SCAN_DIV);
  localparam logic [LW-1:0] BLANK_L = LW'(BLANK);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DIGITS*4-1:0]   act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]     act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     com_q, com_d;
  logic                  tick_q, tick_d;

  logic                  slot_end, frame_end;
  logic [PWM_BITS-1:0]   bright_eff;
  logic [LW-1:0]         on_limit, cnt_l;
  logic                  lit;
  logic [3:0]            nib;
  logic [7:0]            dec;

  // Prescaler and digit index.
  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (idx_q == IDX_MAX);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
  end

  // Pending/active buffers; a load on the boundary cycle goes straight to active.
  always_comb begin
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pend_flag_d = pend_flag_q;
    if (frame_end) begin
      if (load) begin
        act_val_d = digit_val;
        act_dp_d  = digit_dp;
        act_en_d  = digit_en;
      end else if (pend_flag_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
        act_en_d  = pend_en_q;
      end
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_val_d  = digit_val;
      pend_dp_d   = digit_dp;
      pend_en_d   = digit_en;
      pend_flag_d = 1'b1;
    end
  end

  // Brightness is taken live on the slot's first cycle and held for the rest of it.
  always_comb begin
    bright_eff = (cnt_q == '0) ? brightness : bright_q;
    bright_d   = bright_eff;
    on_limit   = ((LW'(bright_eff) + LW'(1)) * DIV_L) >> PWM_BITS;
    cnt_l      = LW'(cnt_q);
    lit        = act_en_q[idx_q] && (cnt_l >= BLANK_L) && (cnt_l < on_limit);
  end

  // Hex decode (active-low, dp off) and next panel outputs.
  always_comb begin
    nib = act_val_q[idx_q*4 +: 4];
    case (nib)
      4'h0: dec = 8'hC0;
      4'h1: dec = 8'hF9;
      4'h2: dec = 8'hA4;
      4'h3: dec = 8'hB0;
      4'h4: dec = 8'h99;
      4'h5: dec = 8'h92;
      4'h6: dec = 8'h82;
      4'h7: dec = 8'hF8;
      4'h8: dec = 8'h80;
      4'h9: dec = 8'h90;
      4'hA: dec = 8'h88;
      4'hB: dec = 8'h83;
      4'hC: dec = 8'hC6;
      4'hD: dec = 8'hA1;
      4'hE: dec = 8'h86;
      default: dec = 8'h8E;
    endcase
    seg_d = '1;
    com_d = '1;
    if (lit) begin
      seg_d        = {~act_dp_q[idx_q], dec[6:0]};
      com_d[idx_q] = 1'b0;
    end
    tick_d = (cnt_q == '0) && (idx_q == '0);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_flag_q <= 1'b0;
      bright_q    <= '0;
      seg_q       <= '1;
      com_q       <= '1;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      pend_flag_q <= pend_flag_d;
      bright_q    <= bright_d;
      seg_q       <= seg_d;
      com_q       <= com_d;
      tick_q      <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign com_out    = com_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan with DIGITS=4, SCAN_DIV=16, PWM_BITS=4, BLANK=2.
module tb_sseg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digit_val = '0;
  logic [3:0]  digit_dp = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  brightness = '0;
  logic [7:0]  seg_out;
  logic [3:0]  com_out;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_seg [64];
  logic [3:0] cap_com [64];

  sseg_scan #(.DIGITS(4), .SCAN_DIV(16), .PWM_BITS(4), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digit_val(digit_val),
    .digit_dp(digit_dp), .digit_en(digit_en), .brightness(brightness),
    .seg_out(seg_out), .com_out(com_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lut(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  // Expected outputs at frame position j (j=0 is the frame_tick cycle).
  function automatic logic [3:0] exp_com(input int j, input logic [3:0] en, input int lim);
    int k = j / 16;
    int c = j % 16;
    if (en[k] && c >= 2 && c < lim) return ~(4'b0001 << k);
    return 4'hF;
  endfunction

  function automatic logic [7:0] exp_seg(input int j, input logic [15:0] v, input logic [3:0] dp,
                                         input logic [3:0] en, input int lim);
    int k = j / 16;
    int c = j % 16;
    if (en[k] && c >= 2 && c < lim) return lut(v[4*k +: 4]) & (dp[k] ? 8'h7F : 8'hFF);
    return 8'hFF;
  endfunction

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_timeout: frame_tick=%b required 1", frame_tick);
    end
  endtask

  task automatic capture_frame();
    wait_tick();
    for (int j = 0; j < 64; j++) begin
      cap_seg[j] = seg_out;
      cap_com[j] = com_out;
      if (j < 63) @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    digit_val = v; digit_dp = dp; digit_en = en; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    int last = -1;
    int nticks = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL rst_seg: got %h want ff", seg_out); end
    checks++; if (com_out !== 4'hF) begin errors++; $display("FAIL rst_com: got %h want f", com_out); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL idle_seg[%0d]: got %h want ff", i, seg_out); end
      checks++; if (com_out !== 4'hF) begin errors++; $display("FAIL idle_com[%0d]: got %h want f", i, com_out); end
      if (frame_tick === 1'b1) begin
        checks++;
        if (last < 0) begin
          if (i != 0) begin errors++; $display("FAIL first_tick: at %0d want 0", i); end
        end else if (i - last != 64) begin
          errors++; $display("FAIL tick_period: got %0d want 64", i - last);
        end
        last = i;
        nticks++;
      end
    end
    checks++; if (nticks != 4) begin errors++; $display("FAIL tick_count: got %0d want 4", nticks); end
  endtask

  task automatic test_full();
    int lit [4];
    brightness = 4'd15;
    do_load(16'h3210, 4'b0000, 4'b1111);
    capture_frame();
    for (int k = 0; k < 4; k++) lit[k] = 0;
    for (int j = 0; j < 64; j++) begin
      if (cap_com[j] != 4'hF) lit[j / 16]++;
      checks++; if (cap_com[j] !== exp_com(j, 4'hF, 16)) begin errors++; $display("FAIL full_com[%0d]: got %h want %h", j, cap_com[j], exp_com(j, 4'hF, 16)); end
      checks++; if (cap_seg[j] !== exp_seg(j, 16'h3210, 4'h0, 4'hF, 16)) begin errors++; $display("FAIL full_seg[%0d]: got %h want %h", j, cap_seg[j], exp_seg(j, 16'h3210, 4'h0, 4'hF, 16)); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (lit[k] != 14) begin errors++; $display("FAIL full_lit[%0d]: got %0d want 14", k, lit[k]); end
    end
    checks++; if (cap_seg[1] !== 8'hFF) begin errors++; $display("FAIL full_blank: got %h want ff", cap_seg[1]); end
    checks++; if (cap_seg[2] !== 8'hC0) begin errors++; $display("FAIL full_d0: got %h want c0", cap_seg[2]); end
    checks++; if (cap_seg[18] !== 8'hF9) begin errors++; $display("FAIL full_d1: got %h want f9", cap_seg[18]); end
    checks++; if (cap_seg[34] !== 8'hA4) begin errors++; $display("FAIL full_d2: got %h want a4", cap_seg[34]); end
    checks++; if (cap_seg[63] !== 8'hB0) begin errors++; $display("FAIL full_d3: got %h want b0", cap_seg[63]); end
  endtask

  task automatic test_dim();
    int lim [3] = '{8, 2, 1};
    logic [3:0] lvl [3] = '{4'd7, 4'd1, 4'd0};
    int want [3] = '{6, 0, 0};
    for (int t = 0; t < 3; t++) begin
      int lit = 0;
      brightness = lvl[t];
      capture_frame();
      for (int j = 0; j < 64; j++) begin
        if (cap_com[j] != 4'hF) lit++;
        checks++; if (cap_com[j] !== exp_com(j, 4'hF, lim[t])) begin errors++; $display("FAIL dim%0d_com[%0d]: got %h want %h", lvl[t], j, cap_com[j], exp_com(j, 4'hF, lim[t])); end
        checks++; if (cap_seg[j] !== exp_seg(j, 16'h3210, 4'h0, 4'hF, lim[t])) begin errors++; $display("FAIL dim%0d_seg[%0d]: got %h want %h", lvl[t], j, cap_seg[j], exp_seg(j, 16'h3210, 4'h0, 4'hF, lim[t])); end
      end
      checks++; if (lit != 4 * want[t]) begin errors++; $display("FAIL dim%0d_lit: got %0d want %0d", lvl[t], lit, 4 * want[t]); end
    end
    brightness = 4'd15;
  endtask

  task automatic test_enable();
    do_load(16'h3210, 4'b0100, 4'b0101);
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      checks++; if (cap_com[j] !== exp_com(j, 4'b0101, 16)) begin errors++; $display("FAIL en_com[%0d]: got %h want %h", j, cap_com[j], exp_com(j, 4'b0101, 16)); end
      checks++; if (cap_seg[j] !== exp_seg(j, 16'h3210, 4'b0100, 4'b0101, 16)) begin errors++; $display("FAIL en_seg[%0d]: got %h want %h", j, cap_seg[j], exp_seg(j, 16'h3210, 4'b0100, 4'b0101, 16)); end
    end
    checks++; if (cap_seg[34] !== 8'h24) begin errors++; $display("FAIL en_dp: got %h want 24", cap_seg[34]); end
    checks++; if (cap_com[34] !== 4'b1011) begin errors++; $display("FAIL en_com2: got %h want b", cap_com[34]); end
    checks++; if (cap_com[18] !== 4'hF) begin errors++; $display("FAIL en_dark1: got %h want f", cap_com[18]); end
  endtask

  task automatic test_last_wins();
    wait_tick();
    for (int j = 0; j < 64; j++) begin
      checks++; if (com_out !== exp_com(j, 4'b0101, 16)) begin errors++; $display("FAIL lw_old_com[%0d]: got %h want %h", j, com_out, exp_com(j, 4'b0101, 16)); end
      checks++; if (seg_out !== exp_seg(j, 16'h3210, 4'b0100, 4'b0101, 16)) begin errors++; $display("FAIL lw_old_seg[%0d]: got %h want %h", j, seg_out, exp_seg(j, 16'h3210, 4'b0100, 4'b0101, 16)); end
      if (j == 10) begin digit_val = 16'h8888; digit_dp = 4'h0; digit_en = 4'hF; load = 1'b1; end
      if (j == 11) load = 1'b0;
      if (j == 30) begin digit_val = 16'hFFFF; load = 1'b1; end
      if (j == 31) load = 1'b0;
      @(negedge clk);
    end
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL lw_tick: got %b want 1", frame_tick); end
    for (int j = 0; j < 64; j++) begin
      checks++; if (com_out !== exp_com(j, 4'hF, 16)) begin errors++; $display("FAIL lw_new_com[%0d]: got %h want %h", j, com_out, exp_com(j, 4'hF, 16)); end
      checks++; if (seg_out !== exp_seg(j, 16'hFFFF, 4'h0, 4'hF, 16)) begin errors++; $display("FAIL lw_new_seg[%0d]: got %h want %h", j, seg_out, exp_seg(j, 16'hFFFF, 4'h0, 4'hF, 16)); end
      if (j == 2) begin
        checks++; if (seg_out !== 8'h8E) begin errors++; $display("FAIL lw_F: got %h want 8e", seg_out); end
      end
      if (j < 63) @(negedge clk);
    end
  endtask

  task automatic test_boundary();
    wait_tick();
    for (int j = 0; j < 64; j++) begin
      checks++; if (seg_out !== exp_seg(j, 16'hFFFF, 4'h0, 4'hF, 16)) begin errors++; $display("FAIL bd_old_seg[%0d]: got %h want %h", j, seg_out, exp_seg(j, 16'hFFFF, 4'h0, 4'hF, 16)); end
      if (j == 62) begin digit_val = 16'hC5A9; digit_dp = 4'h0; digit_en = 4'hF; load = 1'b1; end
      if (j == 63) load = 1'b0;
      @(negedge clk);
    end
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL bd_tick: got %b want 1", frame_tick); end
    for (int j = 0; j < 64; j++) begin
      checks++; if (com_out !== exp_com(j, 4'hF, 16)) begin errors++; $display("FAIL bd_com[%0d]: got %h want %h", j, com_out, exp_com(j, 4'hF, 16)); end
      checks++; if (seg_out !== exp_seg(j, 16'hC5A9, 4'h0, 4'hF, 16)) begin errors++; $display("FAIL bd_seg[%0d]: got %h want %h", j, seg_out, exp_seg(j, 16'hC5A9, 4'h0, 4'hF, 16)); end
      if (j < 63) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    wait_tick();
    repeat (21) @(negedge clk);
    checks++; if (com_out !== 4'b1101) begin errors++; $display("FAIL rm_pre_com: got %h want d", com_out); end
    checks++; if (seg_out !== 8'h88) begin errors++; $display("FAIL rm_pre_seg: got %h want 88", seg_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (com_out !== 4'hF) begin errors++; $display("FAIL rm_async_com: got %h want f", com_out); end
    checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL rm_async_seg: got %h want ff", seg_out); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rm_async_tick: got %b want 0", frame_tick); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checks++; if (frame_tick !== (i == 0)) begin errors++; $display("FAIL rm_tick[%0d]: got %b want %b", i, frame_tick, i == 0); end
      checks++; if (com_out !== 4'hF) begin errors++; $display("FAIL rm_clr_com[%0d]: got %h want f", i, com_out); end
      checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL rm_clr_seg[%0d]: got %h want ff", i, seg_out); end
    end
    do_load(16'h3210, 4'h0, 4'hF);
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      checks++; if (cap_com[j] !== exp_com(j, 4'hF, 16)) begin errors++; $display("FAIL rm_com[%0d]: got %h want %h", j, cap_com[j], exp_com(j, 4'hF, 16)); end
      checks++; if (cap_seg[j] !== exp_seg(j, 16'h3210, 4'h0, 4'hF, 16)) begin errors++; $display("FAIL rm_seg[%0d]: got %h want %h", j, cap_seg[j], exp_seg(j, 16'h3210, 4'h0, 4'hF, 16)); end
    end
    checks++; if (cap_seg[2] !== 8'hC0) begin errors++; $display("FAIL rm_d0: got %h want c0", cap_seg[2]); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_dim();
    test_enable();
    test_last_wins();
    test_boundary();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
